fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter WIDTH, 320, pixels per line swept by a clear.
REQ-002 Parameter HEIGHT, 240, lines swept by a clear.
REQ-003 Parameter COLOR_W, 8, pixel data width.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low; reset==0 at a rising clock edge resets the block.
REQ-006 Port clear_start  input  1  one-cycle request to clear the whole framebuffer.
REQ-007 Port clear_color  input  COLOR_W  fill value, sampled every clear write cycle.
REQ-008 Port draw_req  input  1  drawing client requests one pixel write; held until acked.
REQ-009 Port draw_x  input  11  draw column, valid while draw_req=1.
REQ-010 Port draw_y  input  11  draw row, valid while draw_req=1.
REQ-011 Port draw_color  input  COLOR_W  draw pixel data, valid while draw_req=1.
REQ-012 Port draw_ack  output  1  registered one-cycle acknowledge of the current draw request.
REQ-013 Port fb_we  output  1  registered framebuffer write enable.
REQ-014 Port fb_x  output  11  registered write column.
REQ-015 Port fb_y  output  11  registered write row.
REQ-016 Port fb_data  output  COLOR_W  registered write data.
REQ-017 Port busy  output  1  high while in state CLEAR.
REQ-018 Port clear_done  output  1  one-cycle pulse after the last clear write.

Function
REQ-019 States IDLE and CLEAR; one framebuffer write at most per cycle; all outputs registered.
REQ-020 IDLE, clear_start=1 or clear_pending=1 (and REQ-027 not deferring): next state CLEAR, counters x=0, y=0, clear_pending cleared.
REQ-021 CLEAR, each cycle: fb_we=1, fb_x=x, fb_y=y, fb_data=clear_color; x increments; x==WIDTH-1 wraps to 0 and increments y.
REQ-022 Write at x==WIDTH-1, y==HEIGHT-1 is the last; next cycle clear_done=1, busy=0, fb_we=0, state IDLE; clear lasts exactly WIDTH*HEIGHT write cycles.
REQ-023 clear_start during CLEAR sets clear_pending (one level, not a count); current sweep neither restarts nor aborts.
REQ-024 IDLE, draw_req=1, draw_ack currently 0, no clear starting: next cycle draw_ack=1 and, if draw_x<WIDTH and draw_y<HEIGHT, fb_we=1 with fb_x/fb_y/fb_data = draw_x/draw_y/draw_color.
REQ-025 Out-of-range draw (draw_x>=WIDTH or draw_y>=HEIGHT): draw_ack=1, fb_we=0; request consumed, no write.
REQ-026 Request not accepted in a cycle where draw_ack=1; client advances or drops draw_req after seeing ack; peak draw rate one write per two cycles.
REQ-027 IDLE, clear_start=1 and draw_req=1 together: clear wins, draw_ack stays 0 until clear_done. Exception: on the cycle clear_done=1, if clear_pending=1 and draw_req=1, exactly one draw is served before the pending clear begins.
REQ-028 During CLEAR draw_ack=0; draw_req held without loss.
REQ-029 fb_we=0 and draw_ack=0 in any cycle without a write/acceptance; fb_x/fb_y/fb_data hold last value.
REQ-030 Counter widths 11 bits; no overflow for WIDTH, HEIGHT <= 2047.

Reset
REQ-031 reset==0 at a clock edge: state IDLE, x=0, y=0, clear_pending=0, all outputs 0.
REQ-032 reset mid-CLEAR aborts the sweep immediately; no clear_done pulse; pending clear discarded.
REQ-033 First edge with reset==1 behaves as IDLE with inputs sampled normally.

Verification
REQ-034 clear_start pulse, clear_color=8'h00 -> fb_we high 76800 consecutive cycles, coordinates (0,0)..(319,239) row-major, then clear_done one cycle, busy low.
REQ-035 draw_req with (10,20,8'hA5) in IDLE -> next cycle fb_we=1, fb_x=10, fb_y=20, fb_data=8'hA5, draw_ack=1 for one cycle.
REQ-036 draw_req with (320,5) -> draw_ack=1, fb_we=0.
REQ-037 clear_start and draw_req same cycle, plus second clear_start mid-sweep -> first sweep completes, clear_done, one draw write, then second full sweep.
REQ-038 reset=0 at sweep position (100,50) -> all outputs 0 next cycle, no clear_done, IDLE; subsequent draw_req served normally.
REQ-039 draw_req held continuously with constant data -> draw_ack alternates 1,0,1; writes every other cycle.

Source files
------------

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_write_arbiter
//  Purpose  : Arbitrates framebuffer writes between a full-screen clear sweep
//             and single-pixel draw requests. A clear overwrites every pixel
//             in row-major order, one write per cycle. Draw requests are
//             served only while idle, one write per two cycles at most.
//  Ports    : clock        - sole clock, rising edge
//             reset        - synchronous, active-low
//             clear_start  - one-cycle clear request
//             clear_color  - fill value, sampled on every clear write
//             draw_req     - pixel write request, held until draw_ack
//             draw_x/y     - draw coordinates (11 bit)
//             draw_color   - draw pixel data
//             draw_ack     - one-cycle acknowledge of a draw request
//             fb_we/x/y    - framebuffer write enable and address
//             fb_data      - framebuffer write data
//             busy         - high while a clear sweep is in progress
//             clear_done   - one-cycle pulse after the last clear write
//  Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               draw_req,
    input  logic [10:0]        draw_x,
    input  logic [10:0]        draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               draw_ack,
    output logic               fb_we,
    output logic [10:0]        fb_x,
    output logic [10:0]        fb_y,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic               clear_done
);

    localparam logic [0:0]  c_st_idle  = 1'b0;
    localparam logic [0:0]  c_st_clear = 1'b1;

    localparam logic [10:0] c_width  = 11'(WIDTH);
    localparam logic [10:0] c_height = 11'(HEIGHT);
    localparam logic [10:0] c_x_last = 11'(WIDTH - 1);
    localparam logic [10:0] c_y_last = 11'(HEIGHT - 1);

    logic [0:0]  r_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_pending;
    // Set once the final pixel has been issued; the following cycle closes
    // the sweep and produces the clear_done pulse.
    logic        r_sweep_end;

    logic w_draw_ok;
    logic w_in_range;
    logic w_defer;
    logic w_start;

    // A request cannot be taken in the cycle its acknowledge is showing,
    // which bounds the draw rate to one write every two cycles.
    assign w_draw_ok  = draw_req && !draw_ack;
    assign w_in_range = (draw_x < c_width) && (draw_y < c_height);
    // A queued clear yields for exactly one draw right after a sweep ends,
    // so a client waiting through back-to-back clears is not starved.
    assign w_defer    = clear_done && r_pending && w_draw_ok;
    assign w_start    = (clear_start || r_pending) && !w_defer;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_x         <= 11'd0;
            r_y         <= 11'd0;
            r_pending   <= 1'b0;
            r_sweep_end <= 1'b0;
            draw_ack    <= 1'b0;
            fb_we       <= 1'b0;
            fb_x        <= 11'd0;
            fb_y        <= 11'd0;
            fb_data     <= '0;
            busy        <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            draw_ack   <= 1'b0;
            fb_we      <= 1'b0;
            clear_done <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state     <= c_st_clear;
                        r_x         <= 11'd0;
                        r_y         <= 11'd0;
                        r_pending   <= 1'b0;
                        r_sweep_end <= 1'b0;
                        busy        <= 1'b1;
                    end else if (w_draw_ok) begin
                        // Out-of-range requests are acknowledged and dropped.
                        draw_ack <= 1'b1;
                        if (w_in_range) begin
                            fb_we   <= 1'b1;
                            fb_x    <= draw_x;
                            fb_y    <= draw_y;
                            fb_data <= draw_color;
                        end
                    end
                end

                c_st_clear: begin
                    // Requests during a sweep collapse into a single pending clear.
                    if (clear_start) begin
                        r_pending <= 1'b1;
                    end
                    if (r_sweep_end) begin
                        r_state     <= c_st_idle;
                        r_sweep_end <= 1'b0;
                        busy        <= 1'b0;
                        clear_done  <= 1'b1;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_x    <= r_x;
                        fb_y    <= r_y;
                        fb_data <= clear_color;
                        if (r_x == c_x_last) begin
                            r_x <= 11'd0;
                            if (r_y == c_y_last) begin
                                r_sweep_end <= 1'b1;
                            end else begin
                                r_y <= r_y + 11'd1;
                            end
                        end else begin
                            r_x <= r_x + 11'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_write_arbiter
//  Purpose  : Self-checking bench for fb_write_arbiter. Every expected
//             framebuffer write is queued when stimulus is applied and popped
//             by a write monitor; control outputs are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int W       = 320;
    localparam int H       = 52;
    localparam int COLOR_W = 8;
    localparam int NPIX    = W * H;

    logic               clock;
    logic               reset;
    logic               clear_start;
    logic [COLOR_W-1:0] clear_color;
    logic               draw_req;
    logic [10:0]        draw_x;
    logic [10:0]        draw_y;
    logic [COLOR_W-1:0] draw_color;
    logic               draw_ack;
    logic               fb_we;
    logic [10:0]        fb_x;
    logic [10:0]        fb_y;
    logic [COLOR_W-1:0] fb_data;
    logic               busy;
    logic               clear_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    fb_write_arbiter #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .COLOR_W (COLOR_W)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .draw_req    (draw_req),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_color  (draw_color),
        .draw_ack    (draw_ack),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_data     (fb_data),
        .busy        (busy),
        .clear_done  (clear_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic [10:0] x, input logic [10:0] y,
                                         input logic [COLOR_W-1:0] c);
        return {2'b00, x, y, c};
    endfunction

    task automatic push_sweep(input logic [COLOR_W-1:0] c);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                exp_q.push_back(pack(11'(xx), 11'(yy), c));
            end
        end
    endtask

    // Write monitor: every fb_we cycle must match the head of the queue.
    always @(negedge clock) begin
        if (fb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", pack(fb_x, fb_y, fb_data), 32'hFFFF_FFFF);
            end else begin
                check("write", pack(fb_x, fb_y, fb_data), exp_q.pop_front());
            end
        end
    end

    task automatic do_draw(input logic [10:0] x, input logic [10:0] y,
                           input logic [COLOR_W-1:0] c);
        logic inr;
        inr = (int'(x) < W) && (int'(y) < H);
        draw_req   = 1'b1;
        draw_x     = x;
        draw_y     = y;
        draw_color = c;
        if (inr) exp_q.push_back(pack(x, y, c));
        step();
        check("draw_ack", draw_ack, 1);
        check("draw_we", fb_we, inr);
        draw_req = 1'b0;
        step();
        check("draw_ack_drop", draw_ack, 0);
        check("draw_we_drop", fb_we, 0);
    endtask

    // Runs cycles until clear_done, optionally pulsing clear_start once.
    task automatic wait_done(input int budget, input int pulse_at, output int writes,
                             output int acks, output int first_w, output int last_w,
                             output bit seen);
        writes  = 0;
        acks    = 0;
        first_w = -1;
        last_w  = -1;
        seen    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fb_we) begin
                writes++;
                if (first_w < 0) first_w = i;
                last_w = i;
            end
            if (draw_ack) acks++;
            if (clear_done) begin
                seen = 1'b1;
                break;
            end
            clear_start = (i == pulse_at);
        end
        clear_start = 1'b0;
    endtask

    task automatic check_sweep(input string tag, input int writes, input int acks,
                               input int first_w, input int last_w, input bit seen);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_writes"}, writes, NPIX);
        check({tag, "_contiguous"}, last_w - first_w + 1, NPIX);
        check({tag, "_no_ack"}, acks, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_we_low"}, fb_we, 0);
    endtask

    initial begin
        int  writes, acks, first_w, last_w;
        bit  seen, found;

        reset       = 1'b0;
        clear_start = 1'b0;
        clear_color = '0;
        draw_req    = 1'b0;
        draw_x      = '0;
        draw_y      = '0;
        draw_color  = '0;
        repeat (3) step();

        check("rst_we", fb_we, 0);
        check("rst_x", fb_x, 0);
        check("rst_y", fb_y, 0);
        check("rst_data", fb_data, 0);
        check("rst_ack", draw_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_done", clear_done, 0);

        // First active edge after release already serves a draw.
        reset = 1'b1;
        do_draw(11'd10, 11'd20, 8'hA5);
        do_draw(11'd320, 11'd5, 8'h11);
        do_draw(11'd5, 11'(H), 8'h22);
        do_draw(11'(W - 1), 11'(H - 1), 8'h33);
        do_draw(11'd2047, 11'd2047, 8'h44);
        do_draw(11'd0, 11'd0, 8'h5C);

        // Held request with constant data: ack every other cycle.
        draw_req   = 1'b1;
        draw_x     = 11'd30;
        draw_y     = 11'd40;
        draw_color = 8'h99;
        repeat (3) exp_q.push_back(pack(11'd30, 11'd40, 8'h99));
        for (int k = 0; k < 6; k++) begin
            step();
            check("held_ack", draw_ack, (k % 2 == 0));
            check("held_we", fb_we, (k % 2 == 0));
        end
        draw_req = 1'b0;
        step();
        check("held_ack_drop", draw_ack, 0);

        // Clear and draw together, second clear mid-sweep.
        clear_color = 8'h00;
        clear_start = 1'b1;
        draw_req    = 1'b1;
        draw_x      = 11'd20;
        draw_y      = 11'd30;
        draw_color  = 8'h77;
        push_sweep(8'h00);
        exp_q.push_back(pack(11'd20, 11'd30, 8'h77));
        push_sweep(8'h3C);
        wait_done(NPIX + 20, 1000, writes, acks, first_w, last_w, seen);
        check_sweep("sweep1", writes, acks, first_w, last_w, seen);
        check("sweep1_done_ack", draw_ack, 0);
        clear_color = 8'h3C;
        step();
        check("between_ack", draw_ack, 1);
        check("between_we", fb_we, 1);
        check("between_done_pulse", clear_done, 0);
        check("between_busy", busy, 0);
        draw_req = 1'b0;
        wait_done(NPIX + 20, -1, writes, acks, first_w, last_w, seen);
        check_sweep("sweep2", writes, acks, first_w, last_w, seen);
        step();
        check("post_done_pulse", clear_done, 0);
        check("post_busy", busy, 0);
        check("sweeps_consumed", exp_q.size(), 0);

        // Reset in the middle of a sweep with a clear pending.
        clear_color = 8'hFF;
        clear_start = 1'b1;
        push_sweep(8'hFF);
        found = 1'b0;
        for (int i = 0; i < NPIX + 20; i++) begin
            step();
            if (fb_we && fb_x == 11'd100 && fb_y == 11'd50) begin
                found = 1'b1;
                break;
            end
            clear_start = (i == 500);
        end
        check("reset_pos_reached", found, 1);
        clear_start = 1'b0;
        reset       = 1'b0;
        step();
        check("abort_we", fb_we, 0);
        check("abort_x", fb_x, 0);
        check("abort_y", fb_y, 0);
        check("abort_data", fb_data, 0);
        check("abort_ack", draw_ack, 0);
        check("abort_busy", busy, 0);
        check("abort_done", clear_done, 0);
        exp_q.delete();
        reset = 1'b1;
        do_draw(11'd7, 11'd9, 8'h42);
        for (int k = 0; k < 5; k++) begin
            step();
            check("after_abort_done", clear_done, 0);
            check("after_abort_busy", busy, 0);
        end

        step();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
